// File: rtl/iob_fifo2p_ctrl_pkg.sv
// iob_fifo2p_ctrl_pkg: shared constants and helpers for the two-port-RAM FIFO controller.
// Optional occupancy output is enabled with the IOB_FIFO2P_CTRL_LEVEL_EN macro.
package iob_fifo2p_ctrl_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 10;

    // Depth and pointer width of the default configuration
    localparam int DEPTH = 2 ** DEF_ADDR_W;
    localparam int PTR_W = DEF_ADDR_W + 1;

    // Depth of a FIFO built on a RAM with addr_w address bits
    function automatic int fifo_depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

    // Pointer width: RAM address plus one wrap bit
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // Occupancy = (w_ptr - r_ptr) mod 2**(addr_w+1); 0 means empty, 2**addr_w means full
    function automatic logic [31:0] fifo_occupancy(input logic [31:0] w_ptr,
                                                   input logic [31:0] r_ptr,
                                                   input int          addr_w);
        logic [31:0] mask;
        mask = (32'd1 << (addr_w + 1)) - 32'd1;
        return (w_ptr - r_ptr) & mask;
    endfunction

endpackage

// File: rtl/iob_fifo2p_ptr.sv
// iob_fifo2p_ptr: wrap-around pointer counter with async active-high reset and increment enable.
// Used for both the write and the read pointer of iob_fifo2p_ctrl.
module iob_fifo2p_ptr #(
    parameter int PTR_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    // Advance by one on each accepted transfer; natural roll-over handles the wrap bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/iob_fifo2p_ctrl.sv
// iob_fifo2p_ctrl: FIFO controller in front of an external two-port RAM
// (one write port, one read port with 1-cycle registered data).
// Define IOB_FIFO2P_CTRL_LEVEL_EN to add the level_o occupancy output.
module iob_fifo2p_ctrl
    import iob_fifo2p_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              w_en_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic              w_full_o,
    input  logic              r_en_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic              r_valid_o,
    output logic              r_empty_o,
    output logic              ext_mem_w_en_o,
    output logic [ADDR_W-1:0] ext_mem_w_addr_o,
    output logic [DATA_W-1:0] ext_mem_w_data_o,
    output logic              ext_mem_r_en_o,
    output logic [ADDR_W-1:0] ext_mem_r_addr_o,
    input  logic [DATA_W-1:0] ext_mem_r_data_i
`ifdef IOB_FIFO2P_CTRL_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level_o
`endif
);

    localparam int PTR_BITS   = ptr_width(ADDR_W);
    localparam int FIFO_DEPTH = fifo_depth(ADDR_W);

    logic [PTR_BITS-1:0] w_ptr;
    logic [PTR_BITS-1:0] r_ptr;
    logic [31:0]         occ;
    logic                w_accept;
    logic                r_accept;

    iob_fifo2p_ptr #(.PTR_W(PTR_BITS)) u_w_ptr (
        .clk (clk_i),
        .rst (arst_i),
        .inc (w_accept),
        .ptr (w_ptr)
    );

    iob_fifo2p_ptr #(.PTR_W(PTR_BITS)) u_r_ptr (
        .clk (clk_i),
        .rst (arst_i),
        .inc (r_accept),
        .ptr (r_ptr)
    );

    // Flags come from the registered pointers only; a push never makes a same-cycle pop legal
    assign occ       = fifo_occupancy(32'(w_ptr), 32'(r_ptr), ADDR_W);
    assign r_empty_o = (occ == 32'd0);
    assign w_full_o  = (occ == 32'(FIFO_DEPTH));

`ifdef IOB_FIFO2P_CTRL_LEVEL_EN
    assign level_o = occ[PTR_BITS-1:0];
`endif

    assign w_accept = w_en_i & ~w_full_o;
    assign r_accept = r_en_i & ~r_empty_o;

    // RAM ports: enables only on accepted requests, address/data follow the pointers
    assign ext_mem_w_en_o   = w_accept;
    assign ext_mem_w_addr_o = w_ptr[ADDR_W-1:0];
    assign ext_mem_w_data_o = w_data_i;
    assign ext_mem_r_en_o   = r_accept;
    assign ext_mem_r_addr_o = r_ptr[ADDR_W-1:0];

    // RAM read data is already registered; pass it straight to the consumer
    assign r_data_o = ext_mem_r_data_i;

    // Read-valid tracks the RAM's one-cycle read latency
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_valid_o <= 1'b0;
        end else begin
            r_valid_o <= r_accept;
        end
    end

endmodule

// File: tb/tb_iob_fifo2p_ctrl.sv
// tb_iob_fifo2p_ctrl: randomized self-checking bench for iob_fifo2p_ctrl (ADDR_W=4, DATA_W=32)
// with a behavioural two-port RAM and a queue-based reference model.
module tb_iob_fifo2p_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              arst;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_full;
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_empty;
    logic              m_w_en;
    logic [ADDR_W-1:0] m_w_addr;
    logic [DATA_W-1:0] m_w_data;
    logic              m_r_en;
    logic [ADDR_W-1:0] m_r_addr;
    logic [DATA_W-1:0] m_r_data;
`ifdef IOB_FIFO2P_CTRL_LEVEL_EN
    logic [ADDR_W:0]   level;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mq [$];
    int                vectors = 0;
    int                errors  = 0;

    always #5 clk = ~clk;

    iob_fifo2p_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i            (clk),
        .arst_i           (arst),
        .w_en_i           (w_en),
        .w_data_i         (w_data),
        .w_full_o         (w_full),
        .r_en_i           (r_en),
        .r_data_o         (r_data),
        .r_valid_o        (r_valid),
        .r_empty_o        (r_empty),
        .ext_mem_w_en_o   (m_w_en),
        .ext_mem_w_addr_o (m_w_addr),
        .ext_mem_w_data_o (m_w_data),
        .ext_mem_r_en_o   (m_r_en),
        .ext_mem_r_addr_o (m_r_addr),
        .ext_mem_r_data_i (m_r_data)
`ifdef IOB_FIFO2P_CTRL_LEVEL_EN
        ,
        .level_o          (level)
`endif
    );

    // Two-port RAM: write port plus registered read port
    always @(posedge clk) begin
        if (m_w_en) mem[m_w_addr] <= m_w_data;
        if (m_r_en) m_r_data <= mem[m_r_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_flags();
        check("empty", 32'(r_empty), 32'(mq.size() == 0));
        check("full", 32'(w_full), 32'(mq.size() == DEPTH));
`ifdef IOB_FIFO2P_CTRL_LEVEL_EN
        check("level", 32'(level), 32'(mq.size()));
`endif
    endtask

    // One clock of stimulus; called shortly after a rising edge
    task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d);
        bit                push_ok;
        bit                pop_ok;
        logic [DATA_W-1:0] exp_rd;
        exp_rd = '0;
        w_en   = w;
        r_en   = r;
        w_data = d;
        #1;
        push_ok = w && (mq.size() < DEPTH);
        pop_ok  = r && (mq.size() > 0);
        check_flags();
        check("mem_w_en", 32'(m_w_en), 32'(push_ok));
        check("mem_r_en", 32'(m_r_en), 32'(pop_ok));
        if (push_ok) check("mem_w_data", m_w_data, d);
        @(posedge clk);
        if (pop_ok) exp_rd = mq.pop_front();
        if (push_ok) mq.push_back(d);
        #1;
        check("r_valid", 32'(r_valid), 32'(pop_ok));
        if (pop_ok) check("r_data", r_data, exp_rd);
    endtask

    initial begin
        arst   = 1'b1;
        w_en   = 1'b0;
        r_en   = 1'b0;
        w_data = '0;
        #12;
        check("rst_empty", 32'(r_empty), 32'd1);
        check("rst_full", 32'(w_full), 32'd0);
        check("rst_valid", 32'(r_valid), 32'd0);
`ifdef IOB_FIFO2P_CTRL_LEVEL_EN
        check("rst_level", 32'(level), 32'd0);
`endif
        arst = 1'b0;
        @(posedge clk);
        #1;

        // Pop on empty
        step(1'b0, 1'b1, 32'd0);

        // Fill 32..47, then a rejected 17th push
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'(32 + i));
        step(1'b1, 1'b0, 32'd99);

        // Drain all 16
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // Simultaneous push+pop while empty, at level 5 and while full
        step(1'b1, 1'b1, $urandom);
        while (mq.size() < 5) step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b1, $urandom);
        while (mq.size() < DEPTH) step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b1, $urandom);
        while (mq.size() > 0) step(1'b0, 1'b1, 32'd0);

        // Streaming 40 words at level about 3 across pointer wraps
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 37; i++) step(1'b1, 1'b1, $urandom);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end
        while (mq.size() > 0) step(1'b0, 1'b1, 32'd0);

        // Reset with level 7 and a pop in flight
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $urandom);
        step(1'b0, 1'b1, 32'd0);
        arst = 1'b1;
        #1;
        check("midrst_valid", 32'(r_valid), 32'd0);
        check("midrst_empty", 32'(r_empty), 32'd1);
        check("midrst_full", 32'(w_full), 32'd0);
        mq.delete();
        #2;
        arst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 32'h0000_00A5);
        step(1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/iob_fifo2p_ctrl.md
# iob_fifo2p_ctrl

Synchronous FIFO controller that sits directly upstream of a two-port RAM (one write port, one registered read port) and turns it into a first-in-first-out buffer. It owns the write and read pointers, the full/empty flags and the read-valid tracking. It drives the RAM's write and read ports, and returns the RAM's read data to the consumer. Data storage lives entirely in the external RAM instance.

## Interface
- DATA_W, 32, word width.
- ADDR_W, 10, RAM address width; FIFO depth is 2**ADDR_W.
- clk_i  in  1  clock; all logic is rising-edge.
- arst_i  in  1  reset, asynchronous, active-high.
- w_en_i  in  1  push request.
- w_data_i  in  DATA_W  push data.
- w_full_o  out  1  FIFO full; a push is ignored while high.
- r_en_i  in  1  pop request.
- r_data_o  out  DATA_W  popped word; valid while r_valid_o is high.
- r_valid_o  out  1  high the cycle after an accepted pop.
- r_empty_o  out  1  FIFO empty; a pop is ignored while high.
- level_o  out  ADDR_W+1  occupancy (only with IOB_FIFO2P_CTRL_LEVEL_EN).
- ext_mem_w_en_o  out  1  RAM write enable.
- ext_mem_w_addr_o  out  ADDR_W  RAM write address.
- ext_mem_w_data_o  out  DATA_W  RAM write data.
- ext_mem_r_en_o  out  1  RAM read enable.
- ext_mem_r_addr_o  out  ADDR_W  RAM read address.
- ext_mem_r_data_i  in  DATA_W  RAM read data, registered by the RAM with 1-cycle latency.

## Operation
- Pointers: w_ptr and r_ptr are each ADDR_W+1 bits. The LSBs form the RAM address; the MSB is the wrap bit.
- Empty: w_ptr == r_ptr.
- Full: the LSBs are equal and the MSBs differ.
- Push accepted = w_en_i & !w_full_o.
  - Drive ext_mem_w_en_o=1, ext_mem_w_addr_o=w_ptr[ADDR_W-1:0] and ext_mem_w_data_o=w_data_i combinationally.
  - w_ptr increments at the next edge.
- Pop accepted = r_en_i & !r_empty_o.
  - Drive ext_mem_r_en_o=1 and ext_mem_r_addr_o=r_ptr[ADDR_W-1:0] combinationally.
  - r_ptr increments at the next edge.
  - r_valid_o registers pop-accepted.
- r_data_o is ext_mem_r_data_i passed straight through. It is meaningful only while r_valid_o=1.
- Flags use current-cycle state only; there is no bypass.
  - Push and pop in the same cycle while empty: the push is accepted, the pop is rejected.
  - Push and pop in the same cycle while full: the pop is accepted, the push is rejected.
  - Push and pop in the same cycle otherwise: both are accepted and occupancy is unchanged.
- Because a pop requires non-empty, a read never targets the address being written in the same cycle. RAM write-first/read-first behaviour is therefore irrelevant.
- Wrap-around: pointers roll over from 2**(ADDR_W+1)-1 to 0 with no special case.
- Ignored requests must change no state and must not assert any ext_mem enable.

## Timing
- Reset values (asynchronous, immediate on arst_i):
  - w_ptr=0, r_ptr=0, r_valid_o=0, w_full_o=0, r_empty_o=1, level_o=0.
  - ext_mem enables are 0 because no request is accepted.
- Flags and level are registered-pointer derived and update one cycle after an accepted push/pop.
- Write latency: a word pushed at edge N is poppable from edge N+1; r_empty_o falls after edge N.
- Read latency: pop accepted in cycle N gives r_valid_o=1 and valid r_data_o in cycle N+1.
- Back-to-back pops at 1 word/cycle are supported.
- Reset mid-operation: contents are discarded, and an in-flight r_valid_o is cleared asynchronously.

## Configuration
- IOB_FIFO2P_CTRL_LEVEL_EN defined:
  - level_o exists and equals w_ptr - r_ptr modulo 2**(ADDR_W+1), range 0 to 2**ADDR_W.
  - It is registered alongside the pointers.
- Macro undefined: the level_o port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package (iob_fifo2p_ctrl_pkg) holds:
  - DEPTH = 2**ADDR_W.
  - PTR_W = ADDR_W+1.
  - The occupancy function used for level_o and full/empty derivation.
- One natural sub-module, iob_fifo2p_ptr: a PTR_W-bit counter with async reset and increment enable, instantiated twice (write, read).
- The RAM itself is instantiated by the parent, not inside this block.

## Test plan
Bench uses ADDR_W=4 (depth 16), DATA_W=32, paired with the team's two-port RAM.
- Reset: release arst_i, check outputs; then pop on empty.
  - After reset: r_empty_o=1, w_full_o=0, r_valid_o=0, level_o=0.
  - Pop on empty leaves ext_mem_r_en_o=0 and gives no r_valid_o.
- Fill: push 32..47 on consecutive cycles.
  - After the 16th push: w_full_o=1, level_o=16.
  - A 17th push (value 99) leaves ext_mem_w_en_o=0 and changes nothing.
- Drain: pop 16 times on consecutive cycles.
  - r_valid_o=1 on cycles 1..16 after the first pop, with r_data_o=32..47 in order.
  - Then r_empty_o=1 and level_o=0.
- Simultaneous events:
  - Push+pop while empty: only the push is accepted (level_o 0→1).
  - Push+pop at level 5: level stays 5.
  - Push+pop while full: level 16→15.
- Wrap-around: push/pop 40 words streaming at level ≈ 3.
  - Data order is preserved across both pointer wraps, with no spurious full/empty.
- Reset mid-operation: assert arst_i with level 7 and a pop in flight.
  - r_valid_o drops immediately and r_empty_o=1.
  - A next push of 0xA5 pops back as 0xA5.
